// File: rtl/bac_uploader_if.sv
// Signal bundle between the upload engine, the core memory read port and the
// data_io host upload port.
interface bac_uploader_if #(
    parameter int ADDR_W = 16
);
    logic              start;
    logic [ADDR_W-1:0] start_addr;
    logic [ADDR_W-1:0] length;
    logic              abort;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd;
    logic [7:0]        mem_dout;
    logic              ioctl_upload;
    logic [7:0]        up_data;
    logic              up_valid;
    logic              up_ready;
    logic              busy;
    logic              done;

    modport master (
        output start, start_addr, length, abort, mem_dout, up_ready,
        input  mem_addr, mem_rd, ioctl_upload, up_data, up_valid, busy, done
    );

    modport slave (
        input  start, start_addr, length, abort, mem_dout, up_ready,
        output mem_addr, mem_rd, ioctl_upload, up_data, up_valid, busy, done
    );
endinterface

// File: rtl/bac_uploader.sv
// Upload engine: reads a byte range from core memory and streams it to the
// data_io host upload port through a latency pipe and a 2-entry prefetch FIFO.
module bac_uploader #(
    parameter int MEM_LAT = 1,
    parameter int ADDR_W  = 16
) (
    input logic           clk_sys,
    input logic           reset,
    bac_uploader_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIN
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] issueAddr_q, issueAddr_d;
    logic [ADDR_W-1:0] issueLeft_q, issueLeft_d;
    logic [ADDR_W-1:0] outLeft_q, outLeft_d;
    logic [MEM_LAT-1:0] pipe_q, pipe_d;
    logic [7:0]        fifoMem_q [2];
    logic [7:0]        fifoMem_d [2];
    logic              rdPtr_q, rdPtr_d;
    logic              wrPtr_q, wrPtr_d;
    logic [1:0]        fifoCount_q, fifoCount_d;

    logic [2:0]        inflight;
    logic [3:0]        occupancy;
    logic              issue;
    logic              push;
    logic              pop;
    logic              flush;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < MEM_LAT; i++) begin
            inflight = inflight + 3'(pipe_q[i]);
        end
    end

    assign pop   = (fifoCount_q != 2'd0) && bus.up_ready;
    assign push  = pipe_q[MEM_LAT-1];
    assign flush = bus.abort && (state_q != IDLE);

    // A byte leaving the FIFO this cycle frees its slot, which is what lets
    // the two slots carry one byte per cycle at MEM_LAT=1.
    assign occupancy = {2'b00, fifoCount_q} + {1'b0, inflight} - {3'b000, pop};
    assign issue     = (state_q == RUN) && !bus.abort &&
                       (issueLeft_q != '0) && (occupancy < 4'd2);

    always_comb begin
        state_d     = state_q;
        issueAddr_d = issueAddr_q;
        issueLeft_d = issueLeft_q;
        outLeft_d   = outLeft_q;
        fifoMem_d   = fifoMem_q;
        rdPtr_d     = rdPtr_q;
        wrPtr_d     = wrPtr_q;
        fifoCount_d = fifoCount_q + 2'(push) - 2'(pop);

        pipe_d[0] = issue;
        for (int i = 1; i < MEM_LAT; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end

        if (push) begin
            fifoMem_d[wrPtr_q] = bus.mem_dout;
            wrPtr_d            = ~wrPtr_q;
        end
        if (pop) begin
            rdPtr_d   = ~rdPtr_q;
            outLeft_d = outLeft_q - ADDR_W'(1);
        end
        if (issue) begin
            issueAddr_d = issueAddr_q + ADDR_W'(1);
            issueLeft_d = issueLeft_q - ADDR_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (bus.start && !bus.abort) begin
                    if (bus.length != '0) begin
                        issueAddr_d = bus.start_addr;
                        issueLeft_d = bus.length;
                        outLeft_d   = bus.length;
                        state_d     = RUN;
                    end else begin
                        state_d = FIN;
                    end
                end
            end
            RUN: begin
                if (pop && (outLeft_q == ADDR_W'(1))) begin
                    state_d = FIN;
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Abort drops everything still queued or on its way back from memory.
        if (flush) begin
            state_d     = IDLE;
            pipe_d      = '0;
            fifoCount_d = 2'd0;
            rdPtr_d     = 1'b0;
            wrPtr_d     = 1'b0;
            issueLeft_d = '0;
            outLeft_d   = '0;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q      <= IDLE;
            issueAddr_q  <= '0;
            issueLeft_q  <= '0;
            outLeft_q    <= '0;
            pipe_q       <= '0;
            fifoMem_q[0] <= '0;
            fifoMem_q[1] <= '0;
            rdPtr_q      <= 1'b0;
            wrPtr_q      <= 1'b0;
            fifoCount_q  <= 2'd0;
        end else begin
            state_q      <= state_d;
            issueAddr_q  <= issueAddr_d;
            issueLeft_q  <= issueLeft_d;
            outLeft_q    <= outLeft_d;
            pipe_q       <= pipe_d;
            fifoMem_q    <= fifoMem_d;
            rdPtr_q      <= rdPtr_d;
            wrPtr_q      <= wrPtr_d;
            fifoCount_q  <= fifoCount_d;
        end
    end

    assign bus.mem_rd       = issue;
    assign bus.mem_addr     = issueAddr_q;
    assign bus.ioctl_upload = (state_q == RUN);
    assign bus.up_valid     = (fifoCount_q != 2'd0);
    assign bus.up_data      = fifoMem_q[rdPtr_q];
    assign bus.busy         = (state_q != IDLE);
    assign bus.done         = (state_q == FIN);

    fifoNoOverflow: assert property (@(posedge clk_sys) disable iff (reset)
        !(push && !pop && (fifoCount_q == 2'd2)));

endmodule
